// File: rtl/ariane_pkg.sv
// Types and sizing constants shared by the decode/issue pipeline slice.
package ariane_pkg;

  localparam int unsigned DECODE_QUEUE_DEPTH = 4;
  localparam int unsigned MAX_UNRESOLVED_CF  = 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        valid;
  } scoreboard_entry_t;

  typedef struct packed {
    scoreboard_entry_t instr;
    logic              ctrl_flow;
  } dq_entry_t;

endpackage

// File: rtl/decode_issue_queue_if.sv
// Decode-side and issue-side handshake bundle of the decode issue queue.
interface decode_issue_queue_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic                          flush_i;
  logic                          flush_unissued_instr_i;
  ariane_pkg::scoreboard_entry_t decoded_instr_i;
  logic                          decoded_instr_valid_i;
  logic                          is_ctrl_flow_i;
  logic                          decoded_instr_ack_o;
  ariane_pkg::scoreboard_entry_t issue_instr_o;
  logic                          issue_is_ctrl_flow_o;
  logic                          issue_instr_valid_o;
  logic                          issue_ack_i;
  logic                          resolve_branch_i;
  logic [OCC_W-1:0]              occupancy_o;
  logic                          cf_block_o;

  modport slave (
    input  flush_i, flush_unissued_instr_i, decoded_instr_i, decoded_instr_valid_i,
           is_ctrl_flow_i, issue_ack_i, resolve_branch_i,
    output decoded_instr_ack_o, issue_instr_o, issue_is_ctrl_flow_o,
           issue_instr_valid_o, occupancy_o, cf_block_o
  );

  modport master (
    output flush_i, flush_unissued_instr_i, decoded_instr_i, decoded_instr_valid_i,
           is_ctrl_flow_i, issue_ack_i, resolve_branch_i,
    input  decoded_instr_ack_o, issue_instr_o, issue_is_ctrl_flow_o,
           issue_instr_valid_o, occupancy_o, cf_block_o
  );
endinterface

// File: rtl/decode_issue_queue_cf_credit_counter.sv
// Count of issued-but-unresolved control-flow instructions; flush clears it
// and simultaneous issue + resolve leaves it unchanged.
module cf_credit_counter #(
  parameter  int unsigned MAX = 1,
  localparam int unsigned CW  = $clog2(MAX + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_flush,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_cnt,
  output logic          o_at_limit
);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (i_flush) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt      = r_cnt;
  assign o_at_limit = (r_cnt == CW'(MAX));

  // A resolve with nothing outstanding points at an upstream bookkeeping bug.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(i_dec && !i_inc && !i_flush && (r_cnt == '0)));

endmodule

// File: rtl/decode_issue_queue.sv
// Decode-to-issue decoupling FIFO; ack depends only on occupancy so no
// combinational path crosses it. Control-flow heads wait while the unresolved limit is reached.
module decode_issue_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH          = DECODE_QUEUE_DEPTH,
  parameter int unsigned MAX_UNRESOLVED = MAX_UNRESOLVED_CF
) (
  input logic                  clk_i,
  input logic                  rst_i,
  decode_issue_queue_if.slave  q
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam int unsigned CW = $clog2(MAX_UNRESOLVED + 1);

  dq_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [OW-1:0] r_occ;

  dq_entry_t     w_head;
  logic          w_nonempty;
  logic          w_push;
  logic          w_pop;
  logic          w_flush_q;
  logic          w_cf_inc;
  logic          w_at_limit;
  logic [CW-1:0] w_cf_cnt;

  assign w_head     = r_mem[r_rptr];
  assign w_nonempty = (r_occ != '0);
  assign w_flush_q  = q.flush_i || q.flush_unissued_instr_i;

  assign q.decoded_instr_ack_o  = (r_occ != OW'(DEPTH));
  assign q.cf_block_o           = w_nonempty && w_head.ctrl_flow && w_at_limit;
  assign q.issue_instr_valid_o  = w_nonempty && !q.cf_block_o;
  assign q.issue_instr_o        = w_head.instr;
  assign q.issue_is_ctrl_flow_o = w_head.ctrl_flow;
  assign q.occupancy_o          = r_occ;

  assign w_push = q.decoded_instr_valid_i && q.decoded_instr_ack_o;
  assign w_pop  = q.issue_instr_valid_o && q.issue_ack_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_flush_q) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= '{instr: q.decoded_instr_i, ctrl_flow: q.is_ctrl_flow_i};
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + 1'b1;
      end else if (w_pop && !w_push) begin
        r_occ <= r_occ - 1'b1;
      end
    end
  end

  // A pop squashed by a queue-only flush must not count as issued.
  assign w_cf_inc = w_pop && w_head.ctrl_flow && !q.flush_unissued_instr_i;

  cf_credit_counter #(
    .MAX (MAX_UNRESOLVED)
  ) u_cf_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_flush    (q.flush_i),
    .i_inc      (w_cf_inc),
    .i_dec      (q.resolve_branch_i),
    .o_cnt      (w_cf_cnt),
    .o_at_limit (w_at_limit)
  );

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue with a scoreboard checked on every issue handshake.
module tb_decode_issue_queue;
  import ariane_pkg::*;

  typedef struct {
    scoreboard_entry_t instr;
    logic              cf;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  decode_issue_queue_if #(.DEPTH(DECODE_QUEUE_DEPTH)) bus ();
  decode_issue_queue_if #(.DEPTH(DECODE_QUEUE_DEPTH)) bus2 ();

  decode_issue_queue dut (.clk_i(clk_i), .rst_i(rst_i), .q(bus));
  decode_issue_queue #(.MAX_UNRESOLVED(2)) dut2 (.clk_i(clk_i), .rst_i(rst_i), .q(bus2));

  always #5 clk_i = ~clk_i;

  function automatic scoreboard_entry_t mk(input logic [31:0] pc);
    scoreboard_entry_t e;
    e.pc    = pc;
    e.op    = pc[9:2];
    e.rs1   = pc[6:2];
    e.rs2   = ~pc[6:2];
    e.rd    = pc[8:4];
    e.valid = 1'b1;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.decoded_instr_valid_i  = 1'b0;
    bus.decoded_instr_i        = '0;
    bus.is_ctrl_flow_i         = 1'b0;
    bus.issue_ack_i            = 1'b0;
    bus.resolve_branch_i       = 1'b0;
    bus.flush_i                = 1'b0;
    bus.flush_unissued_instr_i = 1'b0;
  endtask

  // One cycle of stimulus; exp_acc is the hand-computed acceptance of the push.
  task automatic drive(input logic vld, input logic [31:0] pc, input logic cf,
                       input logic iack, input logic res, input logic exp_acc);
    bus.decoded_instr_valid_i = vld;
    bus.decoded_instr_i       = mk(pc);
    bus.is_ctrl_flow_i        = cf;
    bus.issue_ack_i           = iack;
    bus.resolve_branch_i      = res;
    if (vld) begin
      chk($sformatf("push_ack_%0h", pc), bus.decoded_instr_ack_o, exp_acc);
      if (exp_acc) sb.push_back('{mk(pc), cf});
    end
    step();
    idle_inputs();
  endtask

  task automatic drive2(input logic vld, input logic [31:0] pc, input logic iack, input logic res);
    bus2.decoded_instr_valid_i = vld;
    bus2.decoded_instr_i       = mk(pc);
    bus2.is_ctrl_flow_i        = 1'b1;
    bus2.issue_ack_i           = iack;
    bus2.resolve_branch_i      = res;
    step();
    bus2.decoded_instr_valid_i = 1'b0;
    bus2.issue_ack_i           = 1'b0;
    bus2.resolve_branch_i      = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst_i = 1'b1;
    idle_inputs();
    bus2.flush_i = 1'b0;
    bus2.flush_unissued_instr_i = 1'b0;
    bus2.decoded_instr_valid_i = 1'b0;
    bus2.decoded_instr_i = '0;
    bus2.is_ctrl_flow_i = 1'b0;
    bus2.issue_ack_i = 1'b0;
    bus2.resolve_branch_i = 1'b0;

    fork
      forever begin
        @(negedge clk_i);
        if (!rst_i && bus.issue_instr_valid_o && bus.issue_ack_i) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pop_unexpected: got pc %0h, required no issue", bus.issue_instr_o.pc);
          end else begin
            e = sb.pop_front();
            chk($sformatf("pop_instr_%0h", e.instr.pc), bus.issue_instr_o, e.instr);
            chk($sformatf("pop_cf_%0h", e.instr.pc), bus.issue_is_ctrl_flow_o, e.cf);
          end
        end
      end
    join_none

    step();
    step();
    chk("rst_valid", bus.issue_instr_valid_o, 0);
    chk("rst_instr", bus.issue_instr_o, 0);
    chk("rst_cf", bus.issue_is_ctrl_flow_o, 0);
    chk("rst_block", bus.cf_block_o, 0);
    chk("rst_occ", bus.occupancy_o, 0);
    chk("rst_ack", bus.decoded_instr_ack_o, 1);
    chk("rst_cfcnt", dut.u_cf_cnt.o_cnt, 0);
    rst_i = 1'b0;
    step();

    // Fill to DEPTH without issuing, then a refused push.
    for (int i = 0; i < 4; i++) drive(1, 32'h100 + 4 * i, 0, 0, 0, 1);
    chk("fill_occ", bus.occupancy_o, 4);
    chk("fill_ack", bus.decoded_instr_ack_o, 0);
    drive(1, 32'h110, 0, 0, 0, 0);
    chk("fill_occ_hold", bus.occupancy_o, 4);

    // Full with simultaneous pop: push still refused.
    drive(1, 32'h114, 0, 1, 0, 0);
    chk("full_pop_occ", bus.occupancy_o, 3);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0);
    chk("drain_occ", bus.occupancy_o, 0);
    chk("drain_valid", bus.issue_instr_valid_o, 0);

    // No bypass: the pushed entry appears one cycle later.
    bus.decoded_instr_valid_i = 1'b1;
    bus.decoded_instr_i = mk(32'h200);
    #1;
    chk("nobypass_valid", bus.issue_instr_valid_o, 0);
    drive(1, 32'h200, 0, 0, 0, 1);
    chk("latency_valid", bus.issue_instr_valid_o, 1);
    drive(0, 0, 0, 1, 0, 0);

    // Control-flow throttle with a limit of one.
    drive(1, 32'h300, 1, 0, 0, 1);
    drive(1, 32'h304, 1, 0, 0, 1);
    drive(1, 32'h308, 0, 0, 0, 1);
    chk("thr_head_valid", bus.issue_instr_valid_o, 1);
    drive(0, 0, 0, 1, 0, 0);
    chk("thr_cfcnt1", dut.u_cf_cnt.o_cnt, 1);
    chk("thr_block", bus.cf_block_o, 1);
    chk("thr_valid0", bus.issue_instr_valid_o, 0);
    chk("thr_head_pc", bus.issue_instr_o.pc, 32'h304);
    drive(0, 0, 0, 1, 0, 0);
    chk("thr_ack_ignored", bus.occupancy_o, 2);
    drive(0, 0, 0, 0, 1, 0);
    chk("thr_unblock", bus.cf_block_o, 0);
    chk("thr_valid1", bus.issue_instr_valid_o, 1);
    chk("thr_cfcnt0", dut.u_cf_cnt.o_cnt, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("thr_cfcnt_b2", dut.u_cf_cnt.o_cnt, 1);
    chk("thr_plain_valid", bus.issue_instr_valid_o, 1);
    drive(0, 0, 0, 1, 0, 0);
    chk("thr_empty", bus.occupancy_o, 0);

    // Queue-only flush keeps the counter; full flush clears it and beats resolve/push.
    drive(1, 32'h400, 1, 0, 0, 1);
    drive(1, 32'h404, 0, 0, 0, 1);
    drive(1, 32'h408, 0, 0, 0, 1);
    chk("fl_occ3", bus.occupancy_o, 3);
    bus.flush_unissued_instr_i = 1'b1;
    step();
    idle_inputs();
    sb.delete();
    chk("flu_occ", bus.occupancy_o, 0);
    chk("flu_cfcnt", dut.u_cf_cnt.o_cnt, 1);
    chk("flu_valid", bus.issue_instr_valid_o, 0);
    bus.flush_i = 1'b1;
    bus.resolve_branch_i = 1'b1;
    bus.decoded_instr_valid_i = 1'b1;
    bus.decoded_instr_i = mk(32'h500);
    step();
    idle_inputs();
    chk("fl_cfcnt", dut.u_cf_cnt.o_cnt, 0);
    chk("fl_push_dropped", bus.occupancy_o, 0);

    // Ten push/pop pairs wrap the pointers.
    drive(1, 32'h600, 0, 0, 0, 1);
    for (int i = 1; i < 10; i++) begin
      drive(1, 32'h600 + 4 * i, 0, 1, 0, 1);
      chk($sformatf("wrap_occ_%0d", i), bus.occupancy_o, 1);
    end
    drive(0, 0, 0, 1, 0, 0);
    chk("wrap_sb_drained", sb.size(), 0);

    // Asynchronous reset mid-stream.
    drive(1, 32'h700, 1, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 0);
    drive(1, 32'h704, 0, 0, 0, 1);
    drive(1, 32'h708, 0, 0, 0, 1);
    chk("pre_rst_occ", bus.occupancy_o, 2);
    #2;
    rst_i = 1'b1;
    #1;
    sb.delete();
    chk("arst_occ", bus.occupancy_o, 0);
    chk("arst_valid", bus.issue_instr_valid_o, 0);
    chk("arst_ack", bus.decoded_instr_ack_o, 1);
    chk("arst_block", bus.cf_block_o, 0);
    chk("arst_instr", bus.issue_instr_o, 0);
    chk("arst_cf", bus.issue_is_ctrl_flow_o, 0);
    chk("arst_cfcnt", dut.u_cf_cnt.o_cnt, 0);
    step();
    rst_i = 1'b0;
    step();

    // Limit of two: pop of a control-flow entry with a resolve leaves the count alone.
    drive2(1, 32'h800, 0, 0);
    drive2(1, 32'h804, 0, 0);
    drive2(0, 0, 1, 0);
    chk("m2_cfcnt1", dut2.u_cf_cnt.o_cnt, 1);
    chk("m2_valid", bus2.issue_instr_valid_o, 1);
    chk("m2_head_pc", bus2.issue_instr_o.pc, 32'h804);
    drive2(0, 0, 1, 1);
    chk("m2_cfcnt_same", dut2.u_cf_cnt.o_cnt, 1);
    chk("m2_occ", bus2.occupancy_o, 0);
    drive2(0, 0, 0, 1);
    chk("m2_cfcnt0", dut2.u_cf_cnt.o_cnt, 0);

    step();
    chk("sb_empty_end", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
